// File: rtl/ascon_cmd_ctrl.sv
// Command sequencer for ascon_core_sca: decodes host instructions, shares host data
// into Boolean shares, and returns unmasked bdo / tag-verify results on a registered stream.
module ascon_cmd_ctrl #(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned CCW        = 32,
    parameter int unsigned CCSW       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  cmd_data,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [(NUM_SHARES-1)*32-1:0] rnd,
    output logic [31:0]                  res_data,
    output logic [3:0]                   res_type,
    output logic                         res_last,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         err,
    output logic [NUM_SHARES*CCSW-1:0]   key,
    output logic                         key_valid,
    input  logic                         key_ready,
    output logic [NUM_SHARES*CCW-1:0]    bdi,
    output logic                         bdi_valid,
    input  logic                         bdi_ready,
    output logic [3:0]                   bdi_type,
    output logic                         bdi_eot,
    output logic                         bdi_eoi,
    output logic                         decrypt,
    output logic                         hash,
    input  logic [NUM_SHARES*CCW-1:0]    bdo,
    input  logic                         bdo_valid,
    output logic                         bdo_ready,
    input  logic [3:0]                   bdo_type,
    input  logic                         bdo_eot,
    input  logic                         auth,
    input  logic                         auth_valid,
    output logic                         auth_ready
);
    localparam int unsigned BW = NUM_SHARES * CCW;
    localparam int unsigned KW = NUM_SHARES * CCSW;

    localparam logic [3:0] DO_ENC   = 4'd0;
    localparam logic [3:0] DO_DEC   = 4'd1;
    localparam logic [3:0] DO_HASH  = 4'd2;
    localparam logic [3:0] LD_KEY   = 4'd3;
    localparam logic [3:0] LD_NONCE = 4'd4;
    localparam logic [3:0] LD_AD    = 4'd5;
    localparam logic [3:0] LD_PT    = 4'd6;
    localparam logic [3:0] LD_CT    = 4'd7;
    localparam logic [3:0] LD_TAG   = 4'd8;

    localparam logic [3:0] D_NULL   = 4'd0;
    localparam logic [3:0] D_NONCE  = 4'd1;
    localparam logic [3:0] D_AD     = 4'd2;
    localparam logic [3:0] D_PTCT   = 4'd3;
    localparam logic [3:0] D_TAG    = 4'd4;
    localparam logic [3:0] T_VERIFY = 4'hF;

    typedef enum logic [1:0] {IDLE, LOAD, AUTH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ld_op_q, ld_type_q, ld_type_c;
    logic        ld_eoi_q;
    logic [23:0] cnt_q, wc_c;
    logic        auth_pend_q, auth_bit_q;

    logic [3:0]    op_c;
    logic [23:0]   len_c;
    logic [2:0]    unused_flags_c;
    logic          illegal_c, hold_v_c, out_fire_c, cmd_fire_c;
    logic          bdo_fire_c, auth_fire_c, res_free_c;
    logic [BW-1:0] shared_c;
    logic [CCW-1:0] share0_c, bdo_plain_c;

    assign op_c           = cmd_data[31:28];
    assign len_c          = cmd_data[23:0];
    assign unused_flags_c = cmd_data[27:25];
    assign wc_c           = 24'(({1'b0, len_c} + 25'd3) >> 2);
    assign illegal_c      = (op_c > LD_TAG) || (op_c == LD_KEY && len_c != 24'd16);

    assign hold_v_c    = key_valid || bdi_valid;
    assign out_fire_c  = (key_valid && key_ready) || (bdi_valid && bdi_ready);
    assign res_free_c  = !res_valid || res_ready;
    assign cmd_ready   = rst_n && (state_q == IDLE ||
                         (state_q == LOAD && cnt_q != '0 && (!hold_v_c || out_fire_c)));
    assign auth_ready  = rst_n && state_q == AUTH && !auth_pend_q;
    assign bdo_ready   = rst_n && res_free_c && !auth_pend_q;
    assign cmd_fire_c  = cmd_valid && cmd_ready;
    assign bdo_fire_c  = bdo_valid && bdo_ready;
    assign auth_fire_c = auth_valid && auth_ready;
    assign busy        = state_q != IDLE || hold_v_c || res_valid || auth_pend_q;

    // Boolean sharing of the host word; share 0 absorbs every random slice.
    always_comb begin
        shared_c = '0;
        share0_c = cmd_data;
        for (int unsigned i = 1; i < NUM_SHARES; i++) begin
            share0_c                ^= rnd[(i-1)*32 +: 32];
            shared_c[i*CCW +: CCW]   = rnd[(i-1)*32 +: 32];
        end
        shared_c[CCW-1:0] = share0_c;
    end

    always_comb begin
        bdo_plain_c = '0;
        for (int unsigned i = 0; i < NUM_SHARES; i++) begin
            bdo_plain_c ^= bdo[i*CCW +: CCW];
        end
    end

    always_comb begin
        ld_type_c = D_NULL;
        case (op_c)
            LD_NONCE:     ld_type_c = D_NONCE;
            LD_AD:        ld_type_c = D_AD;
            LD_PT, LD_CT: ld_type_c = D_PTCT;
            LD_TAG:       ld_type_c = D_TAG;
            default:      ld_type_c = D_NULL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire_c && !illegal_c && op_c >= LD_KEY) state_d = LOAD;
            LOAD:    if (out_fire_c && cnt_q == '0) state_d = (ld_op_q == LD_TAG) ? AUTH : IDLE;
            AUTH:    if (auth_fire_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Instruction decode, mode flags and the one-entry key/bdi hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decrypt   <= 1'b0;
            hash      <= 1'b0;
            err       <= 1'b0;
            ld_op_q   <= '0;
            ld_type_q <= D_NULL;
            ld_eoi_q  <= 1'b0;
            cnt_q     <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            bdi       <= '0;
            bdi_valid <= 1'b0;
            bdi_type  <= D_NULL;
            bdi_eot   <= 1'b0;
            bdi_eoi   <= 1'b0;
        end else begin
            if (out_fire_c) begin
                key_valid <= 1'b0;
                bdi_valid <= 1'b0;
            end
            if (cmd_fire_c && state_q == IDLE) begin
                if (illegal_c) begin
                    err <= 1'b1;
                end else begin
                    case (op_c)
                        DO_ENC:  begin decrypt <= 1'b0; hash <= 1'b0; end
                        DO_DEC:  begin decrypt <= 1'b1; hash <= 1'b0; end
                        DO_HASH: begin decrypt <= 1'b0; hash <= 1'b1; end
                        default: begin
                            ld_op_q   <= op_c;
                            ld_type_q <= ld_type_c;
                            ld_eoi_q  <= cmd_data[24];
                            cnt_q     <= wc_c;
                            // Empty segment: emit a lone null beat without consuming data words.
                            if (wc_c == '0) begin
                                bdi_valid <= 1'b1;
                                bdi       <= '0;
                                bdi_type  <= D_NULL;
                                bdi_eot   <= 1'b1;
                                bdi_eoi   <= cmd_data[24];
                            end
                        end
                    endcase
                end
            end
            if (cmd_fire_c && state_q == LOAD) begin
                cnt_q <= cnt_q - 24'd1;
                if (ld_op_q == LD_KEY) begin
                    key_valid <= 1'b1;
                    key       <= KW'(shared_c);
                end else begin
                    bdi_valid <= 1'b1;
                    bdi       <= shared_c;
                    bdi_type  <= ld_type_q;
                    bdi_eot   <= cnt_q == 24'd1;
                    bdi_eoi   <= cnt_q == 24'd1 && ld_eoi_q;
                end
            end
        end
    end

    // Result register; a verify result that meets a full register waits in auth_pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_type    <= '0;
            res_last    <= 1'b0;
            auth_pend_q <= 1'b0;
            auth_bit_q  <= 1'b0;
        end else begin
            if (auth_fire_c) auth_bit_q <= auth;
            if (bdo_fire_c) begin
                res_valid <= 1'b1;
                res_data  <= bdo_plain_c;
                res_type  <= bdo_type;
                res_last  <= bdo_eot;
                if (auth_fire_c) auth_pend_q <= 1'b1;
            end else if (auth_pend_q && res_free_c) begin
                res_valid   <= 1'b1;
                res_data    <= {31'b0, auth_bit_q};
                res_type    <= T_VERIFY;
                res_last    <= 1'b1;
                auth_pend_q <= 1'b0;
            end else if (auth_fire_c && res_free_c) begin
                res_valid <= 1'b1;
                res_data  <= {31'b0, auth};
                res_type  <= T_VERIFY;
                res_last  <= 1'b1;
            end else begin
                if (auth_fire_c) auth_pend_q <= 1'b1;
                if (res_ready)   res_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ascon_cmd_ctrl.sv
// Bench for ascon_cmd_ctrl: host and core models with scoreboards for key/bdi/result
// streams, a mode-decode table, and sequences for masking, len=0, tag verify and reset.
module tb_ascon_cmd_ctrl;
    localparam logic [3:0] D_NULL = 4'd0, D_NONCE = 4'd1, D_AD = 4'd2, D_PTCT = 4'd3,
                           D_TAG = 4'd4, T_VERIFY = 4'hF;
    localparam logic [3:0] LD_KEY = 4'd3, LD_NONCE = 4'd4, LD_AD = 4'd5, LD_PT = 4'd6,
                           LD_CT = 4'd7, LD_TAG = 4'd8;

    logic        clk, rst_n;
    logic [31:0] cmd_data, rnd, res_data;
    logic        cmd_valid, cmd_ready, res_last, res_valid, res_ready, busy, err;
    logic [3:0]  res_type, bdi_type, bdo_type;
    logic [63:0] key, bdi, bdo;
    logic        key_valid, key_ready, bdi_valid, bdi_ready, bdi_eot, bdi_eoi;
    logic        decrypt, hash, bdo_valid, bdo_ready, bdo_eot, auth, auth_valid, auth_ready;

    ascon_cmd_ctrl #(.NUM_SHARES(2), .CCW(32), .CCSW(32)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .rnd(rnd), .res_data(res_data), .res_type(res_type),
        .res_last(res_last), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
        .err(err), .key(key), .key_valid(key_valid), .key_ready(key_ready), .bdi(bdi),
        .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type),
        .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .decrypt(decrypt), .hash(hash), .bdo(bdo),
        .bdo_valid(bdo_valid), .bdo_ready(bdo_ready), .bdo_type(bdo_type),
        .bdo_eot(bdo_eot), .auth(auth), .auth_valid(auth_valid), .auth_ready(auth_ready)
    );

    typedef struct packed { logic [63:0] data; logic [3:0] typ; logic eot; logic eoi; } bdi_exp_t;
    typedef struct packed { logic [31:0] data; logic [3:0] typ; logic last; } res_exp_t;
    typedef struct packed { logic [31:0] cmd; logic dec; logic hsh; } mode_vec_t;

    bdi_exp_t    bdi_q[$];
    logic [63:0] key_q[$];
    res_exp_t    res_q[$];
    int          n_tests, n_fail, key_beats;
    bit          core_stall, res_hold;
    logic [180:0] all_out;

    assign all_out = {cmd_ready, res_data, res_type, res_last, res_valid, busy, err, key,
                      key_valid, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, decrypt, hash,
                      bdo_ready, auth_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_type(input logic [3:0] op);
        case (op)
            LD_NONCE:     return D_NONCE;
            LD_AD:        return D_AD;
            LD_PT, LD_CT: return D_PTCT;
            LD_TAG:       return D_TAG;
            default:      return D_NULL;
        endcase
    endfunction

    // Stream monitors: compare every handshake against the scoreboard heads.
    always @(negedge clk) begin
        bdi_exp_t    eb;
        res_exp_t    er;
        logic [63:0] ek;
        if (key_valid && key_ready) begin
            key_beats++;
            if (key_q.size() != 0) ek = key_q.pop_front(); else ek = 'x;
            check("key_beat", 256'(key), 256'(ek));
        end
        if (bdi_valid && bdi_ready) begin
            if (bdi_q.size() != 0) eb = bdi_q.pop_front(); else eb = 'x;
            check("bdi_beat", 256'({bdi, bdi_type, bdi_eot, bdi_eoi}), 256'(eb));
        end
        if (res_valid && res_ready) begin
            if (res_q.size() != 0) er = res_q.pop_front(); else er = 'x;
            check("res_word", 256'({res_data, res_type, res_last}), 256'(er));
        end
    end

    // Core/host sink readiness with random backpressure.
    initial begin
        key_ready = 1'b0; bdi_ready = 1'b0; res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            key_ready = !core_stall && ($urandom_range(0, 3) != 0);
            bdi_ready = !core_stall && ($urandom_range(0, 3) != 0);
            res_ready = !res_hold && ($urandom_range(0, 3) != 0);
        end
    end

    task automatic set_stall(input bit s);
        core_stall = s;
        if (s) begin key_ready = 1'b0; bdi_ready = 1'b0; end
    endtask

    task automatic send_cmd(input logic [31:0] w, input logic [31:0] r);
        int n = 0;
        @(posedge clk); #1;
        cmd_data = w; rnd = r; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        if (!cmd_ready) check("cmd_accept_timeout", 256'(cmd_ready), 256'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_bdo(input logic [31:0] p, input logic [3:0] t, input logic e);
        int n = 0;
        logic [31:0] m;
        @(posedge clk); #1;
        m = $urandom;
        bdo = {m, p ^ m}; bdo_type = t; bdo_eot = e; bdo_valid = 1'b1;
        res_q.push_back('{p, t, e});
        @(negedge clk);
        while (!bdo_ready && n < 500) begin @(negedge clk); n++; end
        if (!bdo_ready) check("bdo_accept_timeout", 256'(bdo_ready), 256'(1));
        @(posedge clk); #1;
        bdo_valid = 1'b0;
    endtask

    task automatic send_auth(input logic a);
        int n = 0;
        @(posedge clk); #1;
        auth = a; auth_valid = 1'b1;
        res_q.push_back('{{31'b0, a}, T_VERIFY, 1'b1});
        @(negedge clk);
        while (!auth_ready && n < 500) begin @(negedge clk); n++; end
        if (!auth_ready) check("auth_accept_timeout", 256'(auth_ready), 256'(1));
        @(posedge clk); #1;
        auth_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] op, input logic [3:0] flags, input int len);
        int nw;
        logic [31:0] w, r;
        bdi_exp_t eb;
        nw = (len + 3) / 4;
        if (nw == 0) bdi_q.push_back('{64'h0, D_NULL, 1'b1, flags[0]});
        send_cmd({op, flags, 24'(len)}, $urandom);
        for (int i = 0; i < nw; i++) begin
            w = $urandom; r = $urandom;
            if (op == LD_KEY) key_q.push_back({r, w ^ r});
            else begin
                eb = '{{r, w ^ r}, exp_type(op), (i == nw - 1), (i == nw - 1) && flags[0]};
                bdi_q.push_back(eb);
            end
            send_cmd(w, r);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((bdi_q.size() + key_q.size() + res_q.size()) != 0 && n < 3000) begin
            @(negedge clk); n++;
        end
        check(name, 256'(bdi_q.size() + key_q.size() + res_q.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic enc_flow();
        int kb;
        send_cmd(32'h0000_0000, 32'h0);
        check("enc_mode", 256'({decrypt, hash}), 256'(0));
        kb = key_beats;
        load(LD_KEY, 4'h0, 16);
        load(LD_NONCE, 4'h0, 16);
        load(LD_AD, 4'h0, 3);
        load(LD_PT, 4'h1, 8);
        wait_drain("enc_load_drain");
        check("enc_key_beats", 256'(key_beats - kb), 256'(4));
        send_bdo($urandom, D_PTCT, 1'b0);
        send_bdo($urandom, D_PTCT, 1'b1);
        for (int i = 0; i < 4; i++) send_bdo($urandom, D_TAG, i == 3);
        wait_drain("enc_result_drain");
        check("enc_idle", 256'(busy), 256'(0));
    endtask

    initial begin
        mode_vec_t mode_tab[5];
        logic [31:0] w1, r1;
        int kb;
        mode_tab[0] = '{32'h1000_0000, 1'b1, 1'b0};
        mode_tab[1] = '{32'h2000_0000, 1'b0, 1'b1};
        mode_tab[2] = '{32'h0000_0000, 1'b0, 1'b0};
        mode_tab[3] = '{32'h1FFF_FFFF, 1'b1, 1'b0};
        mode_tab[4] = '{32'h0000_0005, 1'b0, 1'b0};

        n_tests = 0; n_fail = 0; key_beats = 0;
        core_stall = 1'b0; res_hold = 1'b0;
        rst_n = 1'b0; cmd_data = '0; cmd_valid = 1'b0; rnd = '0;
        bdo = '0; bdo_valid = 1'b0; bdo_type = '0; bdo_eot = 1'b0;
        auth = 1'b0; auth_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 256'(all_out), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_idle_ready", 256'({cmd_ready, busy}), 256'(2'b10));

        for (int i = 0; i < 5; i++) begin
            send_cmd(mode_tab[i].cmd, 32'h0);
            check("mode_table", 256'({decrypt, hash, err, busy}),
                  256'({mode_tab[i].dec, mode_tab[i].hsh, 2'b00}));
        end

        enc_flow();

        // Masking with a fixed random word.
        send_cmd(32'h5000_0004, 32'h0);
        set_stall(1'b1);
        bdi_q.push_back('{{32'hA5A5_A5A5, 32'h0123_4567 ^ 32'hA5A5_A5A5}, D_AD, 1'b1, 1'b0});
        send_cmd(32'h0123_4567, 32'hA5A5_A5A5);
        @(negedge clk);
        check("mask_bdi", 256'({bdi_valid, bdi}), 256'({1'b1, 64'hA5A5_A5A5_A486_E0C2}));
        set_stall(1'b0);
        wait_drain("mask_drain");

        // Empty segment yields one null beat and no data word is taken.
        set_stall(1'b1);
        load(LD_AD, 4'h1, 0);
        @(negedge clk);
        check("len0_beat", 256'({bdi_valid, bdi_type, bdi_eot, bdi_eoi, bdi}),
              256'({1'b1, D_NULL, 1'b1, 1'b1, 64'h0}));
        check("len0_cmd_ready", 256'({cmd_ready, busy}), 256'(2'b01));
        set_stall(1'b0);
        wait_drain("len0_drain");
        @(negedge clk);
        check("len0_back_idle", 256'({cmd_ready, busy}), 256'(2'b10));

        // Decrypt with tag verification arriving while the result register is full.
        send_cmd(32'h1000_0000, 32'h0);
        check("dec_mode", 256'({decrypt, hash}), 256'(2'b10));
        load(LD_KEY, 4'h0, 16);
        load(LD_NONCE, 4'h0, 16);
        load(LD_CT, 4'h0, 4);
        load(LD_TAG, 4'h1, 16);
        wait_drain("dec_load_drain");
        @(negedge clk);
        check("dec_in_auth", 256'({auth_ready, busy, cmd_ready}), 256'(3'b110));
        res_hold = 1'b1; res_ready = 1'b0;
        send_bdo($urandom, D_PTCT, 1'b1);
        send_auth(1'b1);
        @(negedge clk);
        check("auth_pending", 256'({res_valid, res_type, busy, auth_ready, bdo_ready}),
              256'({1'b1, D_PTCT, 1'b1, 1'b0, 1'b0}));
        res_hold = 1'b0;
        wait_drain("dec_result_drain");

        load(LD_TAG, 4'h0, 0);
        wait_drain("tag0_drain");
        @(negedge clk);
        check("tag0_in_auth", 256'(auth_ready), 256'(1));
        send_auth(1'b0);
        wait_drain("tag0_result_drain");
        check("tag0_idle", 256'(busy), 256'(0));

        // Illegal instructions set the sticky error and are dropped.
        kb = key_beats;
        send_cmd(32'hF000_0000, 32'h0);
        check("illegal_op", 256'({err, busy}), 256'(2'b10));
        send_cmd(32'h3000_000C, 32'h0);
        repeat (4) @(negedge clk);
        check("illegal_key", 256'({err, busy, key_valid, cmd_ready}), 256'(4'b1001));
        check("illegal_no_key", 256'(key_beats - kb), 256'(0));

        // Reset during the second plaintext word.
        send_cmd(32'h6100_0008, 32'h0);
        set_stall(1'b1);
        w1 = $urandom; r1 = $urandom;
        bdi_q.push_back('{{r1, w1 ^ r1}, D_PTCT, 1'b0, 1'b0});
        send_cmd(w1, r1);
        @(posedge clk); #1;
        cmd_data = $urandom; cmd_valid = 1'b1;
        @(negedge clk);
        check("rst_word2_blocked", 256'({cmd_ready, bdi_valid}), 256'(2'b01));
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", 256'(all_out), 256'(0));
        #9 rst_n = 1'b1;
        cmd_valid = 1'b0;
        bdi_q.delete();
        set_stall(1'b0);
        @(negedge clk);
        check("rst_recovered", 256'({cmd_ready, err, busy}), 256'(3'b100));
        enc_flow();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
